axis_rx_tlp_decoder: RTL and testbench

AXIS_RX_TLP_DECODER -- requirements
Module: axis_rx_tlp_decoder

---
 rtl/axis_rx_tlp_decoder_if.sv | 43 ++++
 rtl/axis_rx_tlp_decoder.sv | 161 ++++++++++++++++
 tb/tb_axis_rx_tlp_decoder.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_rx_tlp_decoder_if.sv
// Receive-side TLP stream plus the decoded single-DW memory request bus.
// slave  : the decoder's view (consumes the stream, produces requests).
// master : the surrounding logic's view (produces the stream, consumes requests).
interface axis_rx_tlp_decoder_if;
  logic [63:0] s_axis_rx_tdata;
  logic [7:0]  s_axis_rx_tkeep;
  logic        s_axis_rx_tlast;
  logic        s_axis_rx_tvalid;
  logic        s_axis_rx_tready;
  logic [21:0] s_axis_rx_tuser;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [2:0]  mem_req_bar_hit;
  logic [31:0] mem_req_pcie_address;
  logic [7:0]  mem_req_byte_enable;
  logic        mem_req_write_readn;
  logic        mem_req_phys_func;
  logic [63:0] mem_req_write_data;
  logic [15:0] mem_req_requester_id;
  logic [7:0]  mem_req_tag;
  logic [2:0]  mem_req_tc;
  logic [1:0]  mem_req_attr;
  logic        unsupported_req;

  modport slave (
    input  s_axis_rx_tdata, s_axis_rx_tkeep, s_axis_rx_tlast, s_axis_rx_tvalid,
           s_axis_rx_tuser, mem_req_ready,
    output s_axis_rx_tready, mem_req_valid, mem_req_bar_hit, mem_req_pcie_address,
           mem_req_byte_enable, mem_req_write_readn, mem_req_phys_func,
           mem_req_write_data, mem_req_requester_id, mem_req_tag, mem_req_tc,
           mem_req_attr, unsupported_req
  );

  modport master (
    output s_axis_rx_tdata, s_axis_rx_tkeep, s_axis_rx_tlast, s_axis_rx_tvalid,
           s_axis_rx_tuser, mem_req_ready,
    input  s_axis_rx_tready, mem_req_valid, mem_req_bar_hit, mem_req_pcie_address,
           mem_req_byte_enable, mem_req_write_readn, mem_req_phys_func,
           mem_req_write_data, mem_req_requester_id, mem_req_tag, mem_req_tc,
           mem_req_attr, unsupported_req
  );
endinterface

// File: rtl/axis_rx_tlp_decoder.sv
// Decodes single-DW MRd/MWr TLPs (3DW and 4DW headers) from a 64-bit RX
// stream into one memory request each. Anything else, including TLPs whose
// tlast does not land on the last required beat, is swallowed and flagged
// with a one-cycle unsupported_req pulse.
module axis_rx_tlp_decoder #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                 m_axi_aclk,
  input  logic                 m_axi_aresetn,
  axis_rx_tlp_decoder_if.slave bus
);
  localparam int HI = DATA_WIDTH - 1;

  typedef enum logic [2:0] {IDLE, HDR1, DATA4, OUT, DISCARD} state_t;
  state_t state, state_nxt;

  logic [63:0] td;
  logic        hs, last;
  logic [1:0]  fmt;
  logic [4:0]  typ;
  logic [9:0]  len;
  logic [5:0]  bars;
  logic        hdr_ok;
  logic [2:0]  bar_idx;

  logic        rdy_en;
  logic        unsup_q, unsup_nxt;
  logic [2:0]  bar_q;
  logic [15:0] rid_q;
  logic [7:0]  tag_q;
  logic [2:0]  tc_q;
  logic [1:0]  attr_q;
  logic [3:0]  fbe_q;
  logic        wr_q, four_q;
  logic [31:0] addr_q, data_q;

  // tkeep plays no part in decode; fmt/type/length fully qualify a beat.
  logic unused_bits;
  assign unused_bits = ^{bus.s_axis_rx_tkeep, bus.s_axis_rx_tuser[21:8],
                         bus.s_axis_rx_tuser[1:0]};

  assign td   = bus.s_axis_rx_tdata;
  assign last = bus.s_axis_rx_tlast;
  assign hs   = bus.s_axis_rx_tvalid & bus.s_axis_rx_tready;

  assign fmt    = td[30:29];
  assign typ    = td[28:24];
  assign len    = td[9:0];
  assign bars   = bus.s_axis_rx_tuser[7:2];
  assign hdr_ok = (typ == 5'd0) && (len == 10'd1) && (|bars);

  // Lowest set BAR bit wins when several are flagged.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 5; i >= 0; i--)
      if (bars[i]) bar_idx = 3'(i);
  end

  // Next-state and malformed/unsupported detection.
  always_comb begin
    state_nxt = state;
    unsup_nxt = 1'b0;
    case (state)
      IDLE: if (hs) begin
        if (hdr_ok && !last) state_nxt = HDR1;
        else if (!last) begin
          state_nxt = DISCARD;
          unsup_nxt = 1'b1;
        end else unsup_nxt = 1'b1;
      end
      HDR1: if (hs) begin
        if (wr_q && four_q) begin
          if (last) begin
            state_nxt = IDLE;
            unsup_nxt = 1'b1;
          end else state_nxt = DATA4;
        end else if (last) state_nxt = OUT;
        else begin
          state_nxt = DISCARD;
          unsup_nxt = 1'b1;
        end
      end
      DATA4: if (hs) begin
        if (last) state_nxt = OUT;
        else begin
          state_nxt = DISCARD;
          unsup_nxt = 1'b1;
        end
      end
      OUT:     if (bus.mem_req_ready) state_nxt = IDLE;
      DISCARD: if (hs && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, pulse and ready-enable registers; rdy_en keeps tready low until
  // the first edge after reset release.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state   <= IDLE;
      unsup_q <= 1'b0;
      rdy_en  <= 1'b0;
    end else begin
      state   <= state_nxt;
      unsup_q <= unsup_nxt;
      rdy_en  <= 1'b1;
    end
  end

  // Capture header fields at beat0, address/data at beat1 and beat2.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      bar_q  <= '0;
      rid_q  <= '0;
      tag_q  <= '0;
      tc_q   <= '0;
      attr_q <= '0;
      fbe_q  <= '0;
      wr_q   <= 1'b0;
      four_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (hs) begin
      case (state)
        IDLE: begin
          bar_q  <= bar_idx;
          rid_q  <= td[63:48];
          tag_q  <= td[47:40];
          fbe_q  <= td[35:32];
          tc_q   <= td[22:20];
          attr_q <= td[13:12];
          wr_q   <= fmt[1];
          four_q <= fmt[0];
        end
        HDR1: begin
          if (four_q) addr_q <= td[HI:32];
          else begin
            addr_q <= td[31:0];
            data_q <= td[HI:32];
          end
        end
        DATA4:   data_q <= td[31:0];
        default: ;
      endcase
    end
  end

  assign bus.s_axis_rx_tready     = rdy_en & (state != OUT);
  assign bus.mem_req_valid        = (state == OUT);
  assign bus.unsupported_req      = unsup_q;
  assign bus.mem_req_bar_hit      = bar_q;
  assign bus.mem_req_pcie_address = {addr_q[31:2], 2'b00};
  assign bus.mem_req_byte_enable  = addr_q[2] ? {fbe_q, 4'h0} : {4'h0, fbe_q};
  assign bus.mem_req_write_readn  = wr_q;
  assign bus.mem_req_phys_func    = 1'b0;
  assign bus.mem_req_write_data   = wr_q ? {data_q, data_q} : 64'd0;
  assign bus.mem_req_requester_id = rid_q;
  assign bus.mem_req_tag          = tag_q;
  assign bus.mem_req_tc           = tc_q;
  assign bus.mem_req_attr         = attr_q;
endmodule

// File: tb/tb_axis_rx_tlp_decoder.sv
// Bench for axis_rx_tlp_decoder: directed scenarios with literal expectations,
// then randomized TLPs (with tvalid gaps and random mem_req_ready) checked
// against an outcome-per-TLP reference model.
module tb_axis_rx_tlp_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_rx_tlp_decoder_if bus();

  axis_rx_tlp_decoder #(.DATA_WIDTH(64)) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
    .bus           (bus)
  );

  typedef struct {
    bit          is_req;
    logic [2:0]  bar;
    logic [31:0] addr;
    logic [7:0]  be;
    logic        wr;
    logic [63:0] wd;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [1:0]  attr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  logic [63:0] beats [0:3];
  bit          gaps_on = 0;
  bit          rand_ready = 0;
  logic        man_ready = 1'b0;
  logic        armed;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s", nm);
  endtask

  // Outcome of one TLP: a request if it is a supported single-DW MRd/MWr
  // whose beat count matches its header, else one unsupported pulse.
  function automatic exp_t model(input logic [63:0] b0, input logic [63:0] b1,
                                 input logic [63:0] b2, input logic [21:0] tu,
                                 input int nb);
    exp_t e;
    int bar, need;
    logic [31:0] a, d;
    e = '{default: 0};
    bar = -1;
    for (int i = 0; i < 6; i++)
      if (tu[2+i]) begin
        bar = i;
        break;
      end
    need = (b0[30:29] == 2'b11) ? 3 : 2;
    if (b0[28:24] != 5'd0 || b0[9:0] != 10'd1 || bar < 0 || nb != need) return e;
    a = b0[29] ? b1[63:32] : b1[31:0];
    d = b0[29] ? b2[31:0]  : b1[63:32];
    e.is_req = 1;
    e.bar  = 3'(bar);
    e.addr = {a[31:2], 2'b00};
    e.be   = a[2] ? {b0[35:32], 4'h0} : {4'h0, b0[35:32]};
    e.wr   = b0[30];
    e.wd   = b0[30] ? {d, d} : 64'd0;
    e.rid  = b0[63:48];
    e.tag  = b0[47:40];
    e.tc   = b0[22:20];
    e.attr = b0[13:12];
    return e;
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [21:0] u, input logic l);
    int n;
    logic hs;
    if (gaps_on)
      repeat ($urandom_range(0, 2)) begin
        bus.s_axis_rx_tvalid = 1'b0;
        bus.s_axis_rx_tdata  = {$urandom, $urandom};
        bus.s_axis_rx_tlast  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    bus.s_axis_rx_tvalid = 1'b1;
    bus.s_axis_rx_tdata  = d;
    bus.s_axis_rx_tuser  = u;
    bus.s_axis_rx_tlast  = l;
    bus.s_axis_rx_tkeep  = 8'($urandom);
    n = 0;
    hs = 1'b0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = bus.s_axis_rx_tready;
      @(posedge clk); #1;
      n++;
    end
    bus.s_axis_rx_tvalid = 1'b0;
    if (!hs) fail("beat_handshake_timeout");
  endtask

  task automatic send_tlp(input int nb, input logic [21:0] tu);
    exp_q.push_back(model(beats[0], beats[1], beats[2], tu, nb));
    for (int i = 0; i < nb; i++) send_beat(beats[i], tu, (i == nb - 1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_outstanding", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic gen_random();
    logic [1:0]  fmt;
    logic [31:0] dw0;
    logic [5:0]  bars;
    logic [21:0] tu;
    int need, nb, c;
    fmt = 2'($urandom_range(0, 3));
    dw0 = $urandom;
    dw0[30:29] = fmt;
    dw0[28:24] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
    dw0[9:0]   = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : 10'd1;
    c = $urandom_range(0, 9);
    bars = (c == 0) ? 6'd0 : (c < 4) ? 6'($urandom_range(1, 63))
                                     : 6'(1 << $urandom_range(0, 5));
    tu = 22'($urandom);
    tu[7:2] = bars;
    need = (fmt == 2'b11) ? 3 : 2;
    c = $urandom_range(0, 9);
    nb = (c == 0) ? need - 1 : (c == 1) ? need + 1 : need;
    beats[0] = {$urandom, dw0};
    beats[1] = {$urandom, $urandom};
    beats[2] = {$urandom, $urandom};
    beats[3] = {$urandom, $urandom};
    send_tlp(nb, tu);
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;

  // mem_req_ready owner: random in the soak phase, scripted otherwise.
  initial forever begin
    @(posedge clk); #2;
    bus.mem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : man_ready;
  end

  // Compare process: handshake rule, hold stability, and outcome ordering.
  initial begin
    exp_t e;
    exp_t snap;
    logic pv, pr;
    pv = 1'b0;
    pr = 1'b0;
    snap = '{default: 0};
    forever begin
      @(negedge clk);
      if (rst_n && armed) begin
        chk("tready_vs_valid", bus.s_axis_rx_tready, !bus.mem_req_valid);
        if (bus.mem_req_valid && pv && !pr) begin
          chk("hold_addr", bus.mem_req_pcie_address, snap.addr);
          chk("hold_be",   bus.mem_req_byte_enable,  snap.be);
          chk("hold_wd",   bus.mem_req_write_data,   snap.wd);
          chk("hold_tag",  bus.mem_req_tag,          snap.tag);
          chk("hold_bar",  bus.mem_req_bar_hit,      snap.bar);
        end
        if (bus.unsupported_req) begin
          if (exp_q.size() == 0) fail("unsup_unexpected");
          else begin
            e = exp_q.pop_front();
            chk("unsup_but_request_expected", e.is_req, 0);
          end
        end
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          if (exp_q.size() == 0) fail("req_unexpected");
          else begin
            e = exp_q.pop_front();
            chk("req_but_unsup_expected", e.is_req, 1);
            if (e.is_req) begin
              chk("req_bar",  bus.mem_req_bar_hit,      e.bar);
              chk("req_addr", bus.mem_req_pcie_address, e.addr);
              chk("req_be",   bus.mem_req_byte_enable,  e.be);
              chk("req_wr",   bus.mem_req_write_readn,  e.wr);
              chk("req_wd",   bus.mem_req_write_data,   e.wd);
              chk("req_rid",  bus.mem_req_requester_id, e.rid);
              chk("req_tag",  bus.mem_req_tag,          e.tag);
              chk("req_tc",   bus.mem_req_tc,           e.tc);
              chk("req_attr", bus.mem_req_attr,         e.attr);
              chk("req_func", bus.mem_req_phys_func,    0);
            end
          end
        end
        pv = bus.mem_req_valid;
        pr = bus.mem_req_ready;
        snap.addr = bus.mem_req_pcie_address;
        snap.be   = bus.mem_req_byte_enable;
        snap.wd   = bus.mem_req_write_data;
        snap.tag  = bus.mem_req_tag;
        snap.bar  = bus.mem_req_bar_hit;
      end else pv = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_axis_rx_tvalid = 1'b0;
    bus.s_axis_rx_tdata  = '0;
    bus.s_axis_rx_tkeep  = '0;
    bus.s_axis_rx_tlast  = 1'b0;
    bus.s_axis_rx_tuser  = '0;
    bus.mem_req_ready    = 1'b0;
    for (int i = 0; i < 4; i++) beats[i] = '0;

    // Reset values and release behaviour.
    #12;
    chk("rst_valid", bus.mem_req_valid, 0);
    chk("rst_unsup", bus.unsupported_req, 0);
    chk("rst_tready", bus.s_axis_rx_tready, 0);
    chk("rst_addr", bus.mem_req_pcie_address, 0);
    chk("rst_wd", bus.mem_req_write_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("tready_before_first_edge", bus.s_axis_rx_tready, 0);
    @(posedge clk); #1;
    chk("tready_after_first_edge", bus.s_axis_rx_tready, 1);

    // MWr32, 3DW header, addr[2]=1.
    beats[0] = 64'h0000_010F_4000_0001;
    beats[1] = {32'hDEAD_BEEF, 32'h0000_1004};
    send_tlp(2, 22'h8);
    chk("mwr32_valid", bus.mem_req_valid, 1);
    chk("mwr32_wr", bus.mem_req_write_readn, 1);
    chk("mwr32_bar", bus.mem_req_bar_hit, 3'd1);
    chk("mwr32_addr", bus.mem_req_pcie_address, 32'h1004);
    chk("mwr32_be", bus.mem_req_byte_enable, 8'hF0);
    chk("mwr32_wd", bus.mem_req_write_data, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("mwr32_rid", bus.mem_req_requester_id, 16'h0000);
    chk("mwr32_tag", bus.mem_req_tag, 8'h01);
    man_ready = 1'b1;
    wait_drain();
    man_ready = 1'b0;

    // MRd64, 4DW header.
    beats[0] = {32'h0000_2A03, 32'h2000_0001};
    beats[1] = {32'h0000_0008, 32'h0000_0001};
    send_tlp(2, 22'h4);
    chk("mrd64_valid", bus.mem_req_valid, 1);
    chk("mrd64_wr", bus.mem_req_write_readn, 0);
    chk("mrd64_addr", bus.mem_req_pcie_address, 32'h8);
    chk("mrd64_be", bus.mem_req_byte_enable, 8'h03);
    chk("mrd64_tag", bus.mem_req_tag, 8'h2A);
    chk("mrd64_bar", bus.mem_req_bar_hit, 3'd0);
    chk("mrd64_wd", bus.mem_req_write_data, 64'd0);
    man_ready = 1'b1;
    wait_drain();
    man_ready = 1'b0;

    // MWr64 over three beats, request stalled for five cycles.
    beats[0] = {32'hBEEF_5C0F, 32'h6000_0001};
    beats[1] = {32'h0000_123C, 32'h0000_0000};
    beats[2] = {32'h0000_0000, 32'hCAFE_F00D};
    send_tlp(3, 22'h80);
    chk("mwr64_bar", bus.mem_req_bar_hit, 3'd5);
    chk("mwr64_addr", bus.mem_req_pcie_address, 32'h123C);
    chk("mwr64_be", bus.mem_req_byte_enable, 8'hF0);
    chk("mwr64_wd", bus.mem_req_write_data, 64'hCAFE_F00D_CAFE_F00D);
    chk("mwr64_rid", bus.mem_req_requester_id, 16'hBEEF);
    chk("mwr64_tag", bus.mem_req_tag, 8'h5C);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", bus.mem_req_valid, 1);
      chk("stall_tready", bus.s_axis_rx_tready, 0);
      @(posedge clk); #1;
    end
    man_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_done_valid", bus.mem_req_valid, 0);
    chk("stall_done_tready", bus.s_axis_rx_tready, 1);
    man_ready = 1'b0;
    wait_drain();

    // MRd32 with length 2 spanning two beats: discarded.
    man_ready = 1'b1;
    beats[0] = {32'h0000_010F, 32'h0000_0002};
    beats[1] = {32'h1111_2222, 32'h3333_4444};
    send_tlp(2, 22'h4);
    wait_drain();
    chk("len2_tready", bus.s_axis_rx_tready, 1);

    // CfgRd in one beat: pulse on the cycle after the handshake.
    beats[0] = {32'h0000_010F, 32'h0400_0001};
    send_tlp(1, 22'h4);
    chk("cfgrd_pulse", bus.unsupported_req, 1);
    chk("cfgrd_no_req", bus.mem_req_valid, 0);
    @(posedge clk); #1;
    chk("cfgrd_pulse_end", bus.unsupported_req, 0);
    wait_drain();

    // MWr32 cut short at beat0, then a good MRd32.
    beats[0] = 64'h0000_010F_4000_0001;
    send_tlp(1, 22'h8);
    chk("early_last_pulse", bus.unsupported_req, 1);
    beats[0] = {32'h0000_070F, 32'h0000_0001};
    beats[1] = {32'h1234_5678, 32'h0000_0020};
    send_tlp(2, 22'h10);
    chk("after_bad_valid", bus.mem_req_valid, 1);
    chk("after_bad_addr", bus.mem_req_pcie_address, 32'h20);
    chk("after_bad_be", bus.mem_req_byte_enable, 8'h0F);
    chk("after_bad_tag", bus.mem_req_tag, 8'h07);
    chk("after_bad_bar", bus.mem_req_bar_hit, 3'd2);
    wait_drain();

    // Reset while waiting for the MWr64 data beat.
    man_ready = 1'b0;
    send_beat({32'h0102_0F03, 32'h6000_0001}, 22'h4, 1'b0);
    send_beat({32'h0000_0044, 32'h0000_0000}, 22'h4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.mem_req_valid, 0);
    chk("midrst_unsup", bus.unsupported_req, 0);
    chk("midrst_tready", bus.s_axis_rx_tready, 0);
    chk("midrst_addr", bus.mem_req_pcie_address, 0);
    chk("midrst_be", bus.mem_req_byte_enable, 0);
    chk("midrst_rid", bus.mem_req_requester_id, 0);
    chk("midrst_tag", bus.mem_req_tag, 0);
    chk("midrst_wr", bus.mem_req_write_readn, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_release_tready", bus.s_axis_rx_tready, 0);
    @(posedge clk); #1;
    chk("midrst_edge_tready", bus.s_axis_rx_tready, 1);
    beats[0] = 64'h0000_010F_4000_0001;
    beats[1] = {32'h0BAD_F00D, 32'h0000_0008};
    send_tlp(2, 22'h4);
    chk("post_rst_valid", bus.mem_req_valid, 1);
    chk("post_rst_addr", bus.mem_req_pcie_address, 32'h8);
    chk("post_rst_be", bus.mem_req_byte_enable, 8'h0F);
    chk("post_rst_wd", bus.mem_req_write_data, 64'h0BAD_F00D_0BAD_F00D);
    man_ready = 1'b1;
    wait_drain();

    // Randomized soak.
    gaps_on = 1;
    rand_ready = 1;
    repeat (150) gen_random();
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
